// File: rtl/serial_byte_tx.sv
// serial_byte_tx: sends one parallel byte LSB first as eight timed strobes
// (serial_out data, write_out strobe) to a far-end receiver. The receiver's
// ready level (status_in) gates the start, must stay high while bits are sent,
// and must fall again before the byte is reported done.
//
// Ports:
//   clock_1MHz  system clock, all state changes on its rising edge
//   rst         asynchronous active-high reset
//   tx_data     byte to send, captured when tx_valid && tx_ready
//   tx_valid    tx_data valid this cycle
//   tx_ready    high only in IDLE
//   status_in   receiver-ready level from the far end
//   serial_out  current data bit, changes only on STROBE entry
//   write_out   bit strobe, high for STROBE_CYCLES per bit
//   busy        high in every state except IDLE
//   done        one-cycle pulse after the receiver releases status_in
//   abort       one-cycle pulse when status_in drops mid-byte
module serial_byte_tx #(
    parameter int unsigned SETUP_CYCLES  = 10,
    parameter int unsigned STROBE_CYCLES = 10,
    parameter int unsigned GAP_CYCLES    = 10
) (
    input  logic       clock_1MHz,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       status_in,
    output logic       serial_out,
    output logic       write_out,
    output logic       busy,
    output logic       done,
    output logic       abort
);

    localparam int unsigned MAX_SS     = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_SS > GAP_CYCLES) ? MAX_SS : GAP_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_RDY  = 3'd1,
        SETUP     = 3'd2,
        STROBE    = 3'd3,
        GAP       = 3'd4,
        WAIT_DONE = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         shift_q, shift_d;
    logic [2:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic tx_ready_d, serial_d, write_d, busy_d, done_d, abort_d;

    // State register
    always_ff @(posedge clock_1MHz or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, bit index, shift register and in-state cycle counter.
    // The counter restarts at zero on every state change and only runs in
    // the timed states; a timed state ends when it reaches its length - 1.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    shift_d = tx_data;
                    idx_d   = 3'd0;
                    state_d = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (status_in) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (!status_in) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STROBE: begin
                if (!status_in) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(STROBE_CYCLES - 1)) begin
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (!status_in) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    if (idx_q != 3'd7) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = STROBE;
                    end else begin
                        state_d = WAIT_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!status_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line
    // up with the state they describe.
    always_comb begin
        tx_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
        write_d    = (state_d == STROBE);
        serial_d   = serial_out;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        // Data bit is loaded only when entering STROBE, so it is stable
        // for the whole strobe and the following gap.
        if ((state_d == STROBE) && (state_q != STROBE)) begin
            serial_d = shift_q[idx_d];
        end
        if ((state_q == WAIT_DONE) && (state_d == IDLE)) begin
            done_d = 1'b1;
        end
        if (((state_q == SETUP) || (state_q == STROBE) || (state_q == GAP)) && (state_d == IDLE)) begin
            abort_d = 1'b1;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clock_1MHz or posedge rst) begin
        if (rst) begin
            shift_q    <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            tx_ready   <= 1'b1;
            serial_out <= 1'b0;
            write_out  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            abort      <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            tx_ready   <= tx_ready_d;
            serial_out <= serial_d;
            write_out  <= write_d;
            busy       <= busy_d;
            done       <= done_d;
            abort      <= abort_d;
        end
    end

endmodule

// File: tb/tb_serial_byte_tx.sv
// tb_serial_byte_tx: drives serial_byte_tx (default timing and a 1/1/1 timing
// instance) with directed and random bytes and compares every cycle of the
// handshake outputs and the data bit against a timeline model derived from
// the byte, the status_in schedule and the timing parameters.
`timescale 1ns/1ps
module tb_serial_byte_tx;

    localparam int S_S = 10, S_ST = 10, S_G = 10;
    localparam int F_S = 1,  F_ST = 1,  F_G = 1;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       status_in;
    bit         sel;

    logic s_ready, s_ser, s_write, s_busy, s_done, s_abort;
    logic f_ready, f_ser, f_write, f_busy, f_done, f_abort;

    logic [4:0] obs_vec;
    logic       obs_ser;

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #500 clk = ~clk;

    serial_byte_tx dut_slow (
        .clock_1MHz (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (s_ready),
        .status_in  (status_in),
        .serial_out (s_ser),
        .write_out  (s_write),
        .busy       (s_busy),
        .done       (s_done),
        .abort      (s_abort)
    );

    serial_byte_tx #(
        .SETUP_CYCLES  (F_S),
        .STROBE_CYCLES (F_ST),
        .GAP_CYCLES    (F_G)
    ) dut_fast (
        .clock_1MHz (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (f_ready),
        .status_in  (status_in),
        .serial_out (f_ser),
        .write_out  (f_write),
        .busy       (f_busy),
        .done       (f_done),
        .abort      (f_abort)
    );

    // {tx_ready, busy, write_out, abort, done} of the instance under test
    assign obs_vec = sel ? {f_ready, f_busy, f_write, f_abort, f_done}
                         : {s_ready, s_busy, s_write, s_abort, s_done};
    assign obs_ser = sel ? f_ser : s_ser;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One byte. d: negedge after the transfer at which status_in rises
    // (0 = already high). hold: extra WAIT_DONE cycles before status_in
    // falls. abort_t >= 0: status_in falls at that cycle relative to SETUP
    // entry. rst_t >= 0: async reset mid-byte at that cycle.
    task automatic send_byte(input logic [7:0] b, input int d, input int hold,
                             input int abort_t, input bit noise, input int rst_t);
        int s_c, st_c, g_c, p, t_end, setup_start, drop_t, stop_t, last_t, t, ts, idx;
        bit aborted;
        logic [4:0] e;
        s_c  = sel ? F_S  : S_S;
        st_c = sel ? F_ST : S_ST;
        g_c  = sel ? F_G  : S_G;
        p           = st_c + g_c;
        t_end       = s_c + 8 * p;
        setup_start = ((d < 1) ? 1 : d) + 1;
        aborted     = (abort_t >= 0);
        drop_t      = t_end + hold;
        stop_t      = aborted ? abort_t : drop_t;
        last_t      = (rst_t >= 0) ? rst_t : (aborted ? abort_t + 4 : drop_t + 2);

        check("ready_before_tx", 32'(obs_vec[4]), 32'd1);
        tx_data   = b;
        tx_valid  = 1'b1;
        status_in = (d == 0);
        @(posedge clk);
        for (int n = 1; n < 20000; n++) begin
            @(negedge clk);
            t = n - setup_start;
            if (aborted && t > abort_t)
                e = {1'b1, 1'b0, 1'b0, (t == abort_t + 1), 1'b0};
            else if (!aborted && t > drop_t)
                e = {1'b1, 1'b0, 1'b0, 1'b0, (t == drop_t + 1)};
            else
                e = {1'b0, 1'b1, (t >= s_c && t < t_end && ((t - s_c) % p) < st_c), 1'b0, 1'b0};
            check($sformatf("ctl b=%02h t=%0d", b, t), 32'(obs_vec), 32'(e));
            ts = (aborted && t > abort_t) ? abort_t : t;
            if (ts >= s_c) begin
                idx = (ts - s_c) / p;
                if (idx > 7) idx = 7;
                check($sformatf("ser b=%02h t=%0d", b, t), 32'(obs_ser), 32'(b[idx]));
            end
            if (rst_t >= 0 && t == rst_t) begin
                #100;
                rst       = 1'b1;
                tx_valid  = 1'b0;
                status_in = 1'b0;
                #1;
                check($sformatf("rst_mid b=%02h t=%0d", b, t), 32'({obs_vec, obs_ser}), 32'h20);
                #100;
                rst = 1'b0;
                break;
            end
            if (n == d) status_in = 1'b1;
            if (t == stop_t) status_in = 1'b0;
            if (noise && t < stop_t) begin
                tx_valid = 1'($urandom_range(1, 0));
                tx_data  = ($urandom_range(2, 0) == 0) ? 8'h55 : 8'($urandom);
            end else begin
                tx_valid = 1'b0;
            end
            if (t >= last_t) break;
        end
    endtask

    task automatic random_bytes(input int count);
        int t_end, d, hold, ab;
        logic [7:0] b;
        bit noise;
        t_end = sel ? (F_S + 8 * (F_ST + F_G)) : (S_S + 8 * (S_ST + S_G));
        for (int i = 0; i < count; i++) begin
            b     = 8'($urandom);
            d     = int'($urandom_range(6, 0));
            hold  = int'($urandom_range(20, 0));
            ab    = ($urandom_range(1, 0) == 1) ? int'($urandom_range(t_end - 1, 0)) : -1;
            noise = 1'($urandom_range(1, 0));
            send_byte(b, d, hold, ab, noise, -1);
        end
    endtask

    initial begin
        sel       = 1'b0;
        rst       = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        status_in = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_slow", 32'({obs_vec, obs_ser}), 32'h20);
        sel = 1'b1;
        #1;
        check("reset_fast", 32'({obs_vec, obs_ser}), 32'h20);
        sel = 1'b0;
        #1;
        rst = 1'b0;

        // 0x99 with late status, long WAIT_DONE hold and tx_valid noise
        send_byte(8'h99, 5, 50, -1, 1'b1, -1);
        // status drops in the 3rd strobe
        send_byte(8'h99, 2, 0, S_S + 2 * (S_ST + S_G) + 3, 1'b0, -1);
        // reset in the gap after bit 4, then a clean 0xA5
        send_byte(8'h99, 1, 0, -1, 1'b0, S_S + 4 * (S_ST + S_G) + S_ST + 2);
        send_byte(8'hA5, 3, 5, -1, 1'b0, -1);
        random_bytes(4);

        #100;
        rst = 1'b1;
        sel = 1'b1;
        #1;
        check("reset_switch", 32'({obs_vec, obs_ser}), 32'h20);
        #100;
        rst = 1'b0;

        // minimum timing with status already high
        send_byte(8'hC3, 0, 3, -1, 1'b0, -1);
        // reset while write_out is high
        send_byte(8'h3C, 0, 0, -1, 1'b0, F_S + 2 * (F_ST + F_G));
        random_bytes(8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_byte_tx.md
SERIAL_BYTE_TX -- requirements
Module: serial_byte_tx

Interface
REQ-001 The block SHALL have parameter SETUP_CYCLES, default 10, giving the cycles between seeing status_in high and the first write strobe.
REQ-002 The block SHALL have parameter STROBE_CYCLES, default 10, giving the cycles write_out is held high for each bit.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 10, giving the cycles write_out is held low after each strobe.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clock_1MHz  in  1  system clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 tx_data  in  8  parallel byte to send.
REQ-008 tx_valid  in  1  tx_data is valid this cycle.
REQ-009 tx_ready  out  1  block can accept a byte; a transfer occurs when tx_valid and tx_ready are both high at a clock edge.
REQ-010 status_in  in  1  receiver-ready level from the far end; high means the receiver accepts bits.
REQ-011 serial_out  out  1  current serial data bit, LSB first.
REQ-012 write_out  out  1  bit strobe to the receiver; serial_out is stable whenever write_out is high.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse when a byte completes and the receiver has released status_in.
REQ-015 abort  out  1  one-cycle pulse when a byte is abandoned.

Function
REQ-016 The FSM SHALL have the states IDLE, WAIT_RDY, SETUP, STROBE, GAP and WAIT_DONE, with a 3-bit bit index and a timing counter wide enough for the largest parameter.
REQ-017 IDLE: tx_ready=1; on a transfer, latch tx_data into the shift register, clear the bit index and go to WAIT_RDY next cycle.
REQ-018 tx_ready SHALL be 0 in all states other than IDLE; tx_valid outside IDLE SHALL be ignored, and the latched byte SHALL not change.
REQ-019 WAIT_RDY: stay while status_in=0; on status_in=1 go to SETUP; no timeout.
REQ-020 SETUP: last exactly SETUP_CYCLES cycles, then go to STROBE.
REQ-021 STROBE: write_out=1 and serial_out=byte[index] for exactly STROBE_CYCLES cycles, then go to GAP.
REQ-022 GAP: write_out=0 and serial_out held for exactly GAP_CYCLES cycles; then, if index<7, increment the index and go to STROBE, else go to WAIT_DONE.
REQ-023 serial_out SHALL be registered, and SHALL change only on the first cycle of STROBE, never while write_out=1.
REQ-024 WAIT_DONE: stay while status_in=1; on status_in=0, assert done for one cycle and return to IDLE.
REQ-025 If status_in is 0 in any of SETUP, STROBE or GAP, the block SHALL drop write_out on the next edge, assert abort for one cycle and go to IDLE.
REQ-026 An abort SHALL discard the byte and SHALL not retry it.
REQ-027 Per-byte timing SHALL be SETUP_CYCLES + 8*(STROBE_CYCLES+GAP_CYCLES) cycles from SETUP entry to WAIT_DONE entry.
REQ-028 A new byte SHALL be accepted in the cycle after done; there is no back-to-back acceptance while busy.
REQ-029 done and abort SHALL be mutually exclusive and SHALL never both be high in the same cycle.

Reset
REQ-030 When rst=1, the block SHALL immediately and asynchronously set state=IDLE, tx_ready=1, serial_out=0, write_out=0, busy=0, done=0 and abort=0, and clear the shift register, index and counters.
REQ-031 A reset mid-byte SHALL drop write_out within the reset assertion, without waiting for a clock edge, and the byte SHALL be lost.
REQ-032 The first transfer SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-033 tx_data=0x99 accepted, status_in raised after 5 cycles -> 10 idle cycles, then 8 strobes of 10 high/10 low with serial_out = 1,0,0,1,1,0,0,1; busy=1 throughout.
REQ-034 After the 8th GAP, status_in held high for 50 cycles then dropped -> block stays in WAIT_DONE, done pulses once (1 cycle) after the fall, tx_ready=1 the next cycle.
REQ-035 status_in dropped during the 3rd STROBE -> write_out=0 next cycle, abort=1 for one cycle, then IDLE with tx_ready=1, and no further strobes.
REQ-036 tx_valid=1 with tx_data=0x55 asserted while sending 0x99 -> ignored; the bit stream still matches 0x99.
REQ-037 rst pulsed during GAP of bit 4 -> all outputs 0 and tx_ready=1 immediately; a subsequent 0xA5 is sent correctly (1,0,1,0,0,1,0,1).
REQ-038 With SETUP_CYCLES=1, STROBE_CYCLES=1 and GAP_CYCLES=1 and status_in already high -> first strobe 2 cycles after the transfer (1 cycle WAIT_RDY, 1 cycle SETUP) and a 16-cycle bit phase.
